// File: rtl/apb4_ram_slave_if.sv
// APB4 slave-side bus bundle: control, address, data, strobes and response.
interface apb4_ram_slave_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb4_ram_slave.sv
// APB4 scratchpad RAM slave: setup/access FSM, programmable wait states,
// byte-lane writes and PSLVERR for misaligned or out-of-range accesses.
module apb4_ram_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb4_ram_slave_if.slave  bus
);
  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned B  = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IW = ADDR_WIDTH - B;
  localparam int unsigned MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  rd_load_c;
  logic                  mem_we_c;
  logic                  ready_c;
  logic                  mis_c;
  logic                  oor_c;
  logic                  err_c;
  logic [IW-1:0]         idx_c;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Address decode of the live setup-phase address
  assign idx_c = bus.PADDR[ADDR_WIDTH-1:B];
  assign oor_c = 32'(idx_c) >= MEM_DEPTH;
  assign err_c = mis_c | oor_c;

  generate
    if (B == 0) begin : g_no_align
      assign mis_c = 1'b0;
    end else begin : g_align
      assign mis_c = |bus.PADDR[B-1:0];
    end
  endgenerate

  // Response decoded from registered state only
  assign ready_c     = (state_q == ACCESS) && (cnt_q == '0);
  assign bus.PREADY  = ready_c;
  assign bus.PSLVERR = ready_c & err_q;
  assign bus.PRDATA  = prdata_q;

  // Next-state, wait counting and transfer-completion decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    idx_d     = idx_q;
    write_d   = write_q;
    rd_load_c = 1'b0;
    mem_we_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          state_d   = ACCESS;
          cnt_d     = CW'(WAIT_STATES);
          err_d     = err_c;
          idx_d     = idx_c;
          write_d   = bus.PWRITE;
          rd_load_c = !bus.PWRITE;
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else if (bus.PENABLE) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d  = IDLE;
            mem_we_c = write_q & ~err_q & PRESETn;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers and read-data register with synchronous reset
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      if (rd_load_c) begin
        prdata_q <= err_c ? '0 : mem[MW'(idx_c)];
      end
    end
  end

  // Byte-lane RAM write at completion; contents survive reset
  always_ff @(posedge PCLK) begin
    if (mem_we_c) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.PSTRB[i]) begin
          mem[MW'(idx_q)][i*8 +: 8] <= bus.PWDATA[i*8 +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_apb4_ram_slave.sv
// Bench for apb4_ram_slave: three instances (0, 2, 3 wait states) share one
// driven bus with per-instance PSEL; a transaction-level model predicts
// PREADY/PSLVERR/PRDATA every cycle.
module tb_apb4_ram_slave;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 13;
  localparam int unsigned MD = 1024;

  logic          pclk = 1'b0;
  logic          prstn;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  int            tgt;

  int            ws [3] = '{0, 2, 3};
  logic [DW-1:0] mm [3][MD];
  logic [DW-1:0] exp_rdata [3];
  logic          exp_ready [3];
  logic          exp_err   [3];
  logic [DW-1:0] rdata_w   [3];
  logic          ready_w   [3];
  logic          slverr_w  [3];
  bit            chk_en;
  int            checks = 0;
  int            errors = 0;

  always #5 pclk = ~pclk;

  apb4_ram_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
  apb4_ram_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
  apb4_ram_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

  assign b0.PSEL = psel && (tgt == 0);
  assign b1.PSEL = psel && (tgt == 1);
  assign b2.PSEL = psel && (tgt == 2);
  assign b0.PENABLE = penable; assign b1.PENABLE = penable; assign b2.PENABLE = penable;
  assign b0.PWRITE  = pwrite;  assign b1.PWRITE  = pwrite;  assign b2.PWRITE  = pwrite;
  assign b0.PADDR   = paddr;   assign b1.PADDR   = paddr;   assign b2.PADDR   = paddr;
  assign b0.PWDATA  = pwdata;  assign b1.PWDATA  = pwdata;  assign b2.PWDATA  = pwdata;
  assign b0.PSTRB   = pstrb;   assign b1.PSTRB   = pstrb;   assign b2.PSTRB   = pstrb;

  assign rdata_w[0] = b0.PRDATA; assign ready_w[0] = b0.PREADY; assign slverr_w[0] = b0.PSLVERR;
  assign rdata_w[1] = b1.PRDATA; assign ready_w[1] = b1.PREADY; assign slverr_w[1] = b1.PSLVERR;
  assign rdata_w[2] = b2.PRDATA; assign ready_w[2] = b2.PREADY; assign slverr_w[2] = b2.PSLVERR;

  apb4_ram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(MD), .WAIT_STATES(0))
    dut0 (.PCLK(pclk), .PRESETn(prstn), .bus(b0));
  apb4_ram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(MD), .WAIT_STATES(2))
    dut1 (.PCLK(pclk), .PRESETn(prstn), .bus(b1));
  apb4_ram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(MD), .WAIT_STATES(3))
    dut2 (.PCLK(pclk), .PRESETn(prstn), .bus(b2));

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, expv, $time);
    end
  endtask

  // Error rule: misaligned byte address or word index beyond the RAM
  function automatic bit model_err(input logic [AW-1:0] addr);
    return (addr[1:0] != 2'b00) || ((int'(addr) >> 2) >= int'(MD));
  endfunction

  // Per-cycle comparison of every instance against the model
  always @(negedge pclk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("pready%0d", d),  DW'(ready_w[d]),  DW'(exp_ready[d]));
        check($sformatf("pslverr%0d", d), DW'(slverr_w[d]), DW'(exp_err[d]));
        check($sformatf("prdata%0d", d),  rdata_w[d],       exp_rdata[d]);
      end
    end
  end

  // One APB transfer on instance d; abort_at>=0 drops PSEL at that access
  // cycle, rst_at_ready pulses reset in the cycle PREADY is high.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [3:0] strb,
                      input int abort_at, input bit rst_at_ready);
    int w;
    bit e;
    int idx;
    bit aborted;
    w = ws[d];
    e = model_err(addr);
    idx = int'(addr) >> 2;
    aborted = 1'b0;
    tgt = d; psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = data; pstrb = strb;
    exp_ready[d] = 1'b0; exp_err[d] = 1'b0;
    @(posedge pclk); #1;
    if (!wr) exp_rdata[d] = e ? '0 : mm[d][idx];
    penable = 1'b1;
    paddr = addr ^ AW'(13'h0040);
    for (int k = 0; k <= w; k++) begin
      if (!aborted) begin
        if (k == abort_at) begin
          psel = 1'b0;
          exp_ready[d] = 1'b0; exp_err[d] = 1'b0;
          aborted = 1'b1;
        end else begin
          exp_ready[d] = (k == w);
          exp_err[d]   = (k == w) && e;
          if (k == w && rst_at_ready) prstn = 1'b0;
        end
        @(posedge pclk); #1;
      end
    end
    if (rst_at_ready) begin
      prstn = 1'b1;
      for (int dd = 0; dd < 3; dd++) exp_rdata[dd] = '0;
    end else if (wr && !e && !aborted) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) mm[d][idx][i*8 +: 8] = data[i*8 +: 8];
    end
    exp_ready[d] = 1'b0; exp_err[d] = 1'b0;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    prstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; tgt = 0; chk_en = 1'b0;
    for (int d = 0; d < 3; d++) begin
      exp_rdata[d] = '0; exp_ready[d] = 1'b0; exp_err[d] = 1'b0;
    end
    repeat (2) @(posedge pclk);
    #1 prstn = 1'b1;
    chk_en = 1'b1;
    check("reset_prdata0", rdata_w[0], 32'h0);

    // zero wait states: full-word write then read
    xfer(0, 1'b1, 13'h010, 32'hDEADBEEF, 4'hF, -1, 1'b0);
    xfer(0, 1'b0, 13'h010, 32'h0, 4'h0, -1, 1'b0);
    check("lit_rd_010", rdata_w[0], 32'hDEADBEEF);

    // byte strobes
    xfer(0, 1'b1, 13'h020, 32'h11223344, 4'hF, -1, 1'b0);
    xfer(0, 1'b1, 13'h020, 32'hAABBCCDD, 4'h5, -1, 1'b0);
    xfer(0, 1'b0, 13'h020, 32'h0, 4'hA, -1, 1'b0);
    check("lit_strb_020", rdata_w[0], 32'h11BB33DD);

    // three wait states
    xfer(2, 1'b1, 13'h050, 32'h5, 4'hF, -1, 1'b0);
    xfer(2, 1'b0, 13'h050, 32'h0, 4'h0, -1, 1'b0);
    check("lit_ws3_050", rdata_w[2], 32'h5);

    // errors: out-of-range read, misaligned write
    xfer(0, 1'b0, 13'h1000, 32'h0, 4'h0, -1, 1'b0);
    check("lit_oor_rd", rdata_w[0], 32'h0);
    xfer(0, 1'b1, 13'h012, 32'hFFFFFFFF, 4'hF, -1, 1'b0);
    xfer(0, 1'b0, 13'h010, 32'h0, 4'h0, -1, 1'b0);
    check("lit_mis_keep", rdata_w[0], 32'hDEADBEEF);
    xfer(1, 1'b0, 13'h013, 32'h0, 4'h0, -1, 1'b0);
    check("lit_mis_rd_ws2", rdata_w[1], 32'h0);

    // abort during a two-wait-state write
    xfer(1, 1'b1, 13'h030, 32'h12345678, 4'hF, -1, 1'b0);
    xfer(1, 1'b1, 13'h030, 32'hCAFEF00D, 4'hF, 1, 1'b0);
    xfer(1, 1'b0, 13'h030, 32'h0, 4'h0, -1, 1'b0);
    check("lit_abort_030", rdata_w[1], 32'h12345678);

    // back-to-back write then read, no idle cycle
    xfer(0, 1'b1, 13'h040, 32'h1, 4'hF, -1, 1'b0);
    xfer(0, 1'b0, 13'h040, 32'h0, 4'h0, -1, 1'b0);
    check("lit_b2b_040", rdata_w[0], 32'h1);

    // PENABLE without setup: no transfer starts
    tgt = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 13'h040; pwdata = 32'h99999999; pstrb = 4'hF;
    repeat (3) @(posedge pclk);
    #1;
    check("lit_noset_ready", DW'(ready_w[0]), 32'h0);
    psel = 1'b0; penable = 1'b0;
    xfer(0, 1'b0, 13'h040, 32'h0, 4'h0, -1, 1'b0);
    check("lit_noset_mem", rdata_w[0], 32'h1);

    // reset in the completing cycle of a write
    xfer(0, 1'b1, 13'h010, 32'h77777777, 4'hF, -1, 1'b1);
    check("lit_rst_prdata0", rdata_w[0], 32'h0);
    check("lit_rst_prdata2", rdata_w[2], 32'h0);
    check("lit_rst_ready0", DW'(ready_w[0]), 32'h0);
    xfer(0, 1'b0, 13'h010, 32'h0, 4'h0, -1, 1'b0);
    check("lit_rst_nowrite", rdata_w[0], 32'hDEADBEEF);

    repeat (2) @(posedge pclk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
